// File: rtl/req2send_pkg.sv
// Shared defaults and helpers for the multi-channel request-to-send responder.
package req2send_pkg;

   localparam int unsigned DefDataW = 8;
   localparam int unsigned DefNCh   = 4;

   // Channel id width; a single channel still gets a 1-bit id.
   function automatic int unsigned ch_w(input int unsigned n);
      return ($clog2(n) < 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/req2send_mc_if.sv
// Producer/consumer bundle between the channel producers and the responder.
interface req2send_mc_if #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned N_CH   = 4
) ();
   import req2send_pkg::*;

   localparam int unsigned CH_W = ch_w(N_CH);

   logic [N_CH-1:0]        request;
   logic [N_CH*DATA_W-1:0] source_data;
   logic                   clear_ovf;
   logic [N_CH-1:0]        req_busy;
   logic                   ack;
   logic [CH_W-1:0]        ack_ch;
   logic [DATA_W-1:0]      data_out;
   logic [N_CH-1:0]        ovf;

   modport master (
      output request, source_data, clear_ovf,
      input  req_busy, ack, ack_ch, data_out, ovf
   );

   modport slave (
      input  request, source_data, clear_ovf,
      output req_busy, ack, ack_ch, data_out, ovf
   );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after ptr_i.
module rr_arbiter
   import req2send_pkg::*;
#(
   parameter int unsigned N = 4,
   localparam int unsigned CW = ch_w(N)
) (
   input  logic [N-1:0]  req_i,
   input  logic [CW-1:0] ptr_i,
   output logic [N-1:0]  grant_o,
   output logic [CW-1:0] gnt_idx_o
);

   logic        found;
   int unsigned tgt;

   // Visit channels in order ptr, ptr+1, ... mod N and grant the first requester.
   always_comb begin
      grant_o   = '0;
      gnt_idx_o = '0;
      found     = 1'b0;
      tgt       = 0;
      for (int unsigned k = 0; k < N; k++) begin
         tgt = (32'(ptr_i) + k) % N;
         for (int unsigned j = 0; j < N; j++) begin
            if (!found && (j == tgt) && req_i[j]) begin
               found      = 1'b1;
               grant_o[j] = 1'b1;
               gnt_idx_o  = CW'(j);
            end
         end
      end
   end

endmodule

// File: rtl/req2send_mc.sv
// Multi-channel request-to-send responder: one-deep slot per channel, round-robin
// acknowledge of one captured word per cycle, sticky per-channel overflow flags.
module req2send_mc
   import req2send_pkg::*;
#(
   parameter int unsigned DATA_W = DefDataW,
   parameter int unsigned N_CH   = DefNCh
) (
   input logic           clk,
   input logic           reset,
   req2send_mc_if.slave  bus
);

   localparam int unsigned CH_W = ch_w(N_CH);

   typedef struct packed {
      logic              valid;
      logic [DATA_W-1:0] data;
   } slot_t;

   slot_t [N_CH-1:0] slot_q, slot_d;
   logic [CH_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic [N_CH-1:0]  ovf_q, ovf_d;

   logic [N_CH-1:0]   valid;
   logic [N_CH-1:0]   grant;
   logic [N_CH-1:0]   busy;
   logic [N_CH-1:0]   drop;
   logic [CH_W-1:0]   gnt_idx;
   logic              ack;
   logic [DATA_W-1:0] data_out;

   // Unpack slot valid bits for the arbiter.
   always_comb begin
      valid = '0;
      for (int i = 0; i < N_CH; i++) begin
         valid[i] = slot_q[i].valid;
      end
   end

   rr_arbiter #(
      .N (N_CH)
   ) u_arb (
      .req_i     (valid),
      .ptr_i     (rr_ptr_q),
      .grant_o   (grant),
      .gnt_idx_o (gnt_idx)
   );

   // Acknowledge outputs from registered slots only; zero when nothing is granted.
   always_comb begin
      ack      = |grant;
      data_out = '0;
      for (int i = 0; i < N_CH; i++) begin
         if (grant[i]) begin
            data_out = slot_q[i].data;
         end
      end
      // A granted slot frees this cycle, so it can accept a new word.
      busy = valid & ~grant;
      drop = bus.request & busy;
   end

   // Slot capture/release, overflow and pointer next state.
   always_comb begin
      slot_d   = slot_q;
      rr_ptr_d = rr_ptr_q;
      for (int i = 0; i < N_CH; i++) begin
         if (bus.request[i] && (!slot_q[i].valid || grant[i])) begin
            slot_d[i].valid = 1'b1;
            slot_d[i].data  = bus.source_data[i*DATA_W +: DATA_W];
         end else if (grant[i]) begin
            slot_d[i].valid = 1'b0;
         end
      end
      // A new drop in the clear cycle still sets its flag.
      ovf_d = (bus.clear_ovf ? '0 : ovf_q) | drop;
      if (ack) begin
         rr_ptr_d = CH_W'((32'(gnt_idx) + 1) % N_CH);
      end
   end

   // State registers with synchronous reset; requests in the reset cycle are ignored.
   always_ff @(posedge clk) begin
      if (reset) begin
         slot_q   <= '0;
         rr_ptr_q <= '0;
         ovf_q    <= '0;
      end else begin
         slot_q   <= slot_d;
         rr_ptr_q <= rr_ptr_d;
         ovf_q    <= ovf_d;
      end
   end

   assign bus.ack      = ack;
   assign bus.ack_ch   = gnt_idx;
   assign bus.data_out = data_out;
   assign bus.req_busy = busy;
   assign bus.ovf      = ovf_q;

   a_grant_onehot: assert property (@(posedge clk) disable iff (reset) ack |-> $onehot(grant));

endmodule
